// File: rtl/fdiv_ctrl.sv
// rtl/fdiv_ctrl.sv - runtime-configurable clock divider with glitch-free start/stop and divisor reload
module fdiv_ctrl #(
  parameter int CNT_W       = 28,
  parameter int DEFAULT_DIV = 50000000,
  parameter int MIN_DIV     = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic [CNT_W-1:0] cur_div
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] LEGAL_MIN = CNT_W'(MIN_DIV);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             pend_valid_q, pend_valid_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             cfg_err_q, cfg_err_d;
  logic             period_end;
  logic             accept;
  logic             active_d;

  assign period_end = (state_q != IDLE) && (cnt_q == cur_div_q - ONE);
  assign accept     = cfg_valid && !pend_valid_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_div_d    = cur_div_q;
    pend_div_d   = pend_div_q;
    pend_valid_d = pend_valid_q;
    cfg_err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pend_valid_q) begin
          cur_div_d    = pend_div_q;
          pend_valid_d = 1'b0;
        end
        if (en) state_d = RUN;
      end
      RUN, DRAIN: begin
        if (period_end) begin
          // Divisor changes only here, so every emitted period is whole.
          cnt_d = '0;
          if (pend_valid_q) begin
            cur_div_d    = pend_div_q;
            pend_valid_d = 1'b0;
          end
          state_d = en ? RUN : IDLE;
        end else begin
          cnt_d   = cnt_q + ONE;
          state_d = en ? RUN : DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase

    // Apply and accept are exclusive: apply needs pend_valid_q, accept needs it clear.
    if (accept) begin
      if (cfg_div < LEGAL_MIN) begin
        cfg_err_d = 1'b1;
      end else begin
        pend_div_d   = cfg_div;
        pend_valid_d = 1'b1;
      end
    end

    active_d  = (state_d != IDLE);
    clk_out_d = active_d && (cnt_d < (cur_div_d >> 1));
    tick_d    = active_d && (cnt_d == cur_div_d - ONE);
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cur_div_q    <= DEF_DIV;
      pend_div_q   <= '0;
      pend_valid_q <= 1'b0;
      clk_out_q    <= 1'b0;
      tick_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_div_q    <= cur_div_d;
      pend_div_q   <= pend_div_d;
      pend_valid_q <= pend_valid_d;
      clk_out_q    <= clk_out_d;
      tick_q       <= tick_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign cfg_ready = !pend_valid_q;
  assign cfg_err   = cfg_err_q;
  assign clk_out   = clk_out_q;
  assign tick      = tick_q;
  assign running   = (state_q != IDLE);
  assign cur_div   = cur_div_q;

endmodule

// File: tb/tb_fdiv_ctrl.sv
// tb/tb_fdiv_ctrl.sv - scoreboard bench for fdiv_ctrl against a period-level reference model
module tb_fdiv_ctrl;

  localparam int CNT_W = 8;
  localparam int DEF   = 4;
  localparam int MIN   = 2;

  logic             clk_in = 1'b0;
  logic             reset = 1'b0;
  logic             en = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [CNT_W-1:0] cfg_div = '0;
  logic             cfg_ready, cfg_err, clk_out, tick, running;
  logic [CNT_W-1:0] cur_div;

  fdiv_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF), .MIN_DIV(MIN)) dut (
    .clk_in(clk_in), .reset(reset), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .clk_out(clk_out), .tick(tick),
    .running(running), .cur_div(cur_div)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic clk_out;
    logic tick;
    logic running;
    logic cfg_ready;
    logic cfg_err;
    int   cur_div;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model: on/off, position within the period, divisor in effect, pending request.
  bit m_on, m_pv, m_err;
  int m_pos, m_div, m_pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_on = 0; m_pos = 0; m_div = DEF; m_pv = 0; m_pend = 0; m_err = 0;
  endfunction

  task automatic step(input bit e, input bit v, input int d);
    exp_t x;
    bit   acc;
    @(negedge clk_in);
    en = e; cfg_valid = v; cfg_div = d[CNT_W-1:0];
    acc   = v && !m_pv;
    m_err = 0;
    if (!m_on) begin
      if (m_pv) begin m_div = m_pend; m_pv = 0; end
      if (e) begin m_on = 1; m_pos = 0; end
    end else if (m_pos == m_div - 1) begin
      if (m_pv) begin m_div = m_pend; m_pv = 0; end
      m_pos = 0;
      if (!e) m_on = 0;
    end else begin
      m_pos++;
    end
    if (acc) begin
      if (d < MIN) m_err = 1;
      else begin m_pend = d; m_pv = 1; end
    end
    x.clk_out   = m_on && (m_pos < m_div / 2);
    x.tick      = m_on && (m_pos == m_div - 1);
    x.running   = m_on;
    x.cfg_ready = !m_pv;
    x.cfg_err   = m_err;
    x.cur_div   = m_div;
    exp_q.push_back(x);
  endtask

  always @(posedge clk_in) begin
    #1;
    if (reset && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("clk_out", 32'(clk_out), 32'(mon_e.clk_out));
      chk("tick", 32'(tick), 32'(mon_e.tick));
      chk("running", 32'(running), 32'(mon_e.running));
      chk("cfg_ready", 32'(cfg_ready), 32'(mon_e.cfg_ready));
      chk("cfg_err", 32'(cfg_err), 32'(mon_e.cfg_err));
      chk("cur_div", 32'(cur_div), 32'(mon_e.cur_div));
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_clk_out"}, 32'(clk_out), 32'd0);
    chk({tag, "_tick"}, 32'(tick), 32'd0);
    chk({tag, "_running"}, 32'(running), 32'd0);
    chk({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
    chk({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
    chk({tag, "_cur_div"}, 32'(cur_div), 32'(DEF));
  endtask

  task automatic release_reset();
    @(negedge clk_in);
    en = 0; cfg_valid = 0; cfg_div = '0;
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk_in);
    chk_reset_state("rst");
    release_reset();

    // Default divisor 4, then stop
    repeat (12) step(1, 0, 0);
    repeat (6) step(0, 0, 0);

    // Odd divisor loaded while idle
    step(0, 1, 5);
    repeat (2) step(0, 0, 0);
    repeat (15) step(1, 0, 0);

    // Illegal requests while running
    step(1, 1, 1);
    repeat (3) step(1, 0, 0);
    step(1, 1, 0);
    repeat (6) step(1, 0, 0);
    repeat (8) step(0, 0, 0);

    // Back to 4, then reconfigure to 6 mid-period
    step(0, 1, 4);
    repeat (2) step(0, 0, 0);
    repeat (2) step(1, 0, 0);
    step(1, 1, 6);
    repeat (14) step(1, 0, 0);
    repeat (8) step(0, 0, 0);

    // Back to 4; drain with a stop at cnt=1, then restart during a drain
    step(0, 1, 4);
    repeat (2) step(0, 0, 0);
    repeat (2) step(1, 0, 0);
    repeat (6) step(0, 0, 0);
    repeat (2) step(1, 0, 0);
    step(0, 0, 0);
    repeat (8) step(1, 0, 0);
    repeat (6) step(0, 0, 0);

    // Async reset between edges with a pending divisor and clk_out high
    step(1, 1, 7);
    @(negedge clk_in);
    cfg_valid = 0;
    chk("pre_rst_clk_out", 32'(clk_out), 32'd1);
    chk("pre_rst_cfg_ready", 32'(cfg_ready), 32'd0);
    #2 reset = 1'b0;
    #1 chk_reset_state("async");
    repeat (2) @(negedge clk_in);
    release_reset();
    repeat (2) step(0, 0, 0);
    repeat (10) step(1, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0, int'($urandom_range(0, 9)));
    end
    repeat (12) step(0, 0, 0);

    @(posedge clk_in);
    #3;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
